// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: widths, canonical NOP, reset vector, fetch FSM states.
// Pure declarations; no latency, no backpressure.
package riscv_pkg;
   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   typedef enum logic {IDLE, WAIT} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding slot for a response that IF/ID cannot take; 1-cycle fill-to-use.
// Never refuses a fill; the fetch FSM stops requesting whenever this slot would still be occupied.
module fetch_skid_buf #(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            fill,
   input  logic            drain,
   input  logic [31:0]     fill_instr,
   input  logic [XLEN-1:0] fill_pc,
   output logic            vld,
   output logic            vld_next,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc
);
   import riscv_pkg::*;

   // A fill in the same cycle as a drain means the slot is reloaded, not emptied.
   assign vld_next = !clear && (fill || (vld && !drain));

   always_ff @(posedge clk) begin
      if (rst) begin
         vld   <= 1'b0;
         instr <= 32'h0;
         pc    <= '0;
      end else begin
         vld <= vld_next;
         if (fill && !clear) begin
            instr <= fill_instr;
            pc    <= fill_pc;
         end
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// PC, single-outstanding imem handshake and IF/ID register; instr reaches instrD 2 cycles after its request.
// Backpressure: stallD holds IF/ID, one skid slot absorbs a late response, requests stop while it stays full.
module fetch_stage #(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stallF,
   input  logic            stallD,
   input  logic            flushD,
   input  logic            pcsrcE,
   input  logic [XLEN-1:0] pctargetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instrD,
   output logic [XLEN-1:0] pcD,
   output logic [XLEN-1:0] pcplus4D,
   output logic            validD
);
   import riscv_pkg::*;

   fetch_state_t    state, state_nxt;
   logic            kill, kill_nxt;
   logic [XLEN-1:0] pcf;
   logic [XLEN-1:0] reqpc;
   logic            hs;
   logic            rv_ok;
   logic            buf_clear, buf_fill, buf_drain;
   logic            buf_vld, buf_vld_next;
   logic [31:0]     buf_instr;
   logic [XLEN-1:0] buf_pc;
   logic            unused_tgt_lsb;

   assign unused_tgt_lsb = ^pctargetE[1:0];

   // Responses are only honoured for a live, non-killed request.
   assign rv_ok     = imem_rvalid && (state == WAIT) && !kill;
   assign buf_clear = pcsrcE || flushD;
   assign buf_drain = buf_vld && !stallD;
   assign buf_fill  = rv_ok && (stallD || buf_vld);

   // Issue only if the skid slot will be free at the end of this cycle, so the reply always has a home.
   assign imem_req  = !rst && !stallF && !pcsrcE && !kill &&
                      ((state == IDLE) || imem_rvalid) && !buf_vld_next;
   assign hs        = imem_req && imem_ready;
   assign imem_addr = {pcf[XLEN-1:2], 2'b00};

   always_comb begin
      state_nxt = state;
      kill_nxt  = kill;
      case (state)
         IDLE: if (hs) state_nxt = WAIT;
         WAIT: begin
            if (imem_rvalid) begin
               state_nxt = hs ? WAIT : IDLE;
               kill_nxt  = 1'b0;
            end else if (pcsrcE) begin
               kill_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         kill  <= 1'b0;
      end else begin
         state <= state_nxt;
         kill  <= kill_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcf   <= RESET_PC;
         reqpc <= '0;
      end else begin
         if (pcsrcE)  pcf <= {pctargetE[XLEN-1:2], 2'b00};
         else if (hs) pcf <= pcf + XLEN'(4);
         if (hs) reqpc <= pcf;
      end
   end

   fetch_skid_buf #(.XLEN(XLEN)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .clear      (buf_clear),
      .fill       (buf_fill),
      .drain      (buf_drain),
      .fill_instr (imem_rdata),
      .fill_pc    (reqpc),
      .vld        (buf_vld),
      .vld_next   (buf_vld_next),
      .instr      (buf_instr),
      .pc         (buf_pc)
   );

   always_ff @(posedge clk) begin
      if (rst || flushD || pcsrcE) begin
         validD   <= 1'b0;
         instrD   <= NOP_INSTR;
         pcD      <= '0;
         pcplus4D <= '0;
      end else if (stallD) begin
         validD   <= validD;
      end else if (buf_vld) begin
         validD   <= 1'b1;
         instrD   <= buf_instr;
         pcD      <= buf_pc;
         pcplus4D <= buf_pc + XLEN'(4);
      end else if (rv_ok) begin
         validD   <= 1'b1;
         instrD   <= imem_rdata;
         pcD      <= reqpc;
         pcplus4D <= reqpc + XLEN'(4);
      end else begin
         validD   <= 1'b0;
         instrD   <= NOP_INSTR;
         pcD      <= '0;
         pcplus4D <= '0;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus redirect, flush and reset sequences.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stallF, stallD, flushD, pcsrcE;
   logic [31:0] pctargetE;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready, imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instrD, pcD, pcplus4D;
   logic        validD;

   fetch_stage dut (
      .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
      .pcsrcE(pcsrcE), .pctargetE(pctargetE),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD)
   );

   int checks = 0;
   int errors = 0;

   // Memory model: one pending response, returned mem_lat cycles after the cycle following handshake.
   logic        pend_vld;
   logic [31:0] pend_addr;
   int          pend_wait;
   int          mem_lat;

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic sf, input logic sd, input logic fl, input logic ps,
                        input logic [31:0] tgt, input logic rdy);
      stallF = sf; stallD = sd; flushD = fl; pcsrcE = ps; pctargetE = tgt; imem_ready = rdy;
   endtask

   task automatic tick();
      logic        hs;
      logic [31:0] a;
      #1;
      hs = imem_req && imem_ready;
      a  = imem_addr;
      @(posedge clk);
      #1;
      if (imem_rvalid) pend_vld = 1'b0;
      imem_rvalid = 1'b0;
      if (hs) begin
         pend_vld  = 1'b1;
         pend_addr = a;
         pend_wait = mem_lat;
      end else if (pend_vld && pend_wait > 0) begin
         pend_wait--;
      end
      if (pend_vld && pend_wait == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = word(pend_addr);
      end
   endtask

   typedef struct {
      logic        sd;
      logic        rdy;
      int          lat;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
   } vec_t;

   function automatic vec_t mk(input logic sd, input logic rdy, input int lat, input logic e_req,
                               input logic [31:0] e_addr, input logic e_vld, input logic [31:0] e_pc);
      vec_t v;
      v.sd = sd; v.rdy = rdy; v.lat = lat;
      v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
      v.e_instr = e_vld ? word(e_pc) : NOP;
      return v;
   endfunction

   vec_t vt[14];

   initial begin
      // stallD, ready, lat | req, addr, validD, pcD  (one row per cycle after reset)
      vt[0]  = mk(0, 1, 0, 1, 32'h00, 0, 32'h00);
      vt[1]  = mk(0, 1, 0, 1, 32'h04, 0, 32'h00);
      vt[2]  = mk(0, 1, 0, 1, 32'h08, 1, 32'h00);
      vt[3]  = mk(0, 1, 0, 1, 32'h0C, 1, 32'h04);
      vt[4]  = mk(0, 0, 0, 1, 32'h10, 1, 32'h08);
      vt[5]  = mk(0, 0, 0, 1, 32'h10, 1, 32'h0C);
      vt[6]  = mk(0, 0, 0, 1, 32'h10, 0, 32'h00);
      vt[7]  = mk(0, 1, 0, 1, 32'h10, 0, 32'h00);
      vt[8]  = mk(0, 1, 0, 1, 32'h14, 0, 32'h00);
      vt[9]  = mk(1, 1, 0, 0, 32'h18, 1, 32'h10);
      vt[10] = mk(1, 1, 0, 0, 32'h18, 1, 32'h10);
      vt[11] = mk(0, 1, 0, 1, 32'h18, 1, 32'h10);
      vt[12] = mk(0, 1, 0, 1, 32'h1C, 1, 32'h14);
      vt[13] = mk(0, 1, 2, 1, 32'h20, 1, 32'h18);

      pend_vld = 1'b0; pend_addr = '0; pend_wait = 0; mem_lat = 0;
      imem_rvalid = 1'b0; imem_rdata = '0;
      rst = 1'b1;
      drive(0, 0, 0, 0, 32'h0, 1);
      #1;
      check("req_in_reset", {31'b0, imem_req}, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_validD", {31'b0, validD}, 32'h0);
      check("rst_instrD", instrD, NOP);
      check("rst_pcD", pcD, 32'h0);
      check("rst_pcplus4D", pcplus4D, 32'h0);

      // Streaming, ready-low wait states, then stallD with a response landing in the skid slot.
      for (int i = 0; i < 14; i++) begin
         drive(0, vt[i].sd, 0, 0, 32'h0, vt[i].rdy);
         mem_lat = vt[i].lat;
         #1;
         check($sformatf("row%0d_req", i), {31'b0, imem_req}, {31'b0, vt[i].e_req});
         if (vt[i].e_req) check($sformatf("row%0d_addr", i), imem_addr, vt[i].e_addr);
         check($sformatf("row%0d_validD", i), {31'b0, validD}, {31'b0, vt[i].e_vld});
         check($sformatf("row%0d_instrD", i), instrD, vt[i].e_instr);
         if (vt[i].e_vld) begin
            check($sformatf("row%0d_pcD", i), pcD, vt[i].e_pc);
            check($sformatf("row%0d_pcplus4D", i), pcplus4D, vt[i].e_pc + 32'd4);
         end
         tick();
      end

      // Redirect to an unaligned target while the 0x20 request is still outstanding.
      mem_lat = 0;
      drive(0, 0, 0, 1, 32'h103, 1);
      #1;
      check("redir_req", {31'b0, imem_req}, 32'h0);
      check("redir_prev_instr", instrD, word(32'h1C));
      tick();
      drive(0, 0, 0, 0, 32'h0, 1);
      #1;
      check("redir_bubble_validD", {31'b0, validD}, 32'h0);
      check("redir_bubble_instrD", instrD, NOP);
      check("redir_wait_req", {31'b0, imem_req}, 32'h0);
      tick();
      #1;
      check("killed_rvalid_req", {31'b0, imem_req}, 32'h0);
      check("killed_validD", {31'b0, validD}, 32'h0);
      tick();
      #1;
      check("redir_req_issue", {31'b0, imem_req}, 32'h1);
      check("redir_addr", imem_addr, 32'h100);
      tick();
      #1;
      check("redir_validD_wait", {31'b0, validD}, 32'h0);
      check("redir_addr_next", imem_addr, 32'h104);
      tick();
      #1;
      check("redir_validD", {31'b0, validD}, 32'h1);
      check("redir_pcD", pcD, 32'h100);
      check("redir_instrD", instrD, word(32'h100));
      check("redir_pcplus4D", pcplus4D, 32'h104);

      // flushD and stallD together: flush wins.
      drive(0, 1, 1, 0, 32'h0, 1);
      tick();
      drive(0, 0, 0, 0, 32'h0, 1);
      #1;
      check("flush_validD", {31'b0, validD}, 32'h0);
      check("flush_instrD", instrD, NOP);
      check("flush_pcD", pcD, 32'h0);
      tick();
      #1;
      check("post_flush_pcD", pcD, 32'h108);
      check("post_flush_instrD", instrD, word(32'h108));
      check("post_flush_addr", imem_addr, 32'h110);
      mem_lat = 1;
      tick();

      // Reset while WAIT; the late response lands in the first cycle after reset.
      rst = 1'b1;
      #1;
      check("midwait_rst_req", {31'b0, imem_req}, 32'h0);
      tick();
      rst = 1'b0;
      mem_lat = 0;
      #1;
      check("post_rst_rvalid_seen", {31'b0, imem_rvalid}, 32'h1);
      check("post_rst_validD", {31'b0, validD}, 32'h0);
      check("post_rst_instrD", instrD, NOP);
      check("post_rst_pcD", pcD, 32'h0);
      check("post_rst_pcplus4D", pcplus4D, 32'h0);
      check("post_rst_req", {31'b0, imem_req}, 32'h1);
      check("post_rst_addr", imem_addr, 32'h0);
      tick();
      #1;
      check("stale_ignored_validD", {31'b0, validD}, 32'h0);
      check("restart_addr", imem_addr, 32'h4);
      tick();
      #1;
      check("restart_validD", {31'b0, validD}, 32'h1);
      check("restart_instrD", instrD, word(32'h0));
      check("restart_pcD", pcD, 32'h0);
      check("restart_pcplus4D", pcplus4D, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Fetch stage plus IF/ID pipeline register of the 5-stage RV32I core, directly upstream of decode. It owns the PC and runs a one-outstanding-request handshake to instruction memory. It buffers one returned instruction and presents instrD/pcD/pcplus4D to decode. It consumes the hazard unit's stallF, stallD and flushD, plus the execute-stage redirect (pcsrcE, pctargetE), and inserts bubbles (NOP) whenever memory has not delivered.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stallF  in  1  hazard unit: hold PC, issue no new request
stallD  in  1  hazard unit: hold IF/ID register contents
flushD  in  1  hazard unit: squash IF/ID register to bubble
pcsrcE  in  1  execute-stage taken branch/jump
pctargetE  in  XLEN  redirect target
imem_req  out  1  request valid
imem_addr  out  XLEN  request address, bits [1:0] forced to 0
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
instrD  out  32  instruction to decode
pcD  out  XLEN  PC of instrD
pcplus4D  out  XLEN  pcD+4
validD  out  1  instrD is real (0 = bubble)

Behaviour:
- Reset (rst=1 at edge): pcF=RESET_PC, state IDLE, kill=0, buffer empty, validD=0, instrD=32'h0000_0013 (NOP), pcD=0, pcplus4D=0. imem_req is combinationally 0 while rst=1.
- State machine, at most one outstanding request:
  - IDLE -> WAIT on handshake (imem_req && imem_ready).
  - WAIT -> IDLE on imem_rvalid.
  - A new request may issue in the same cycle rvalid returns.
- imem_req = !rst && !stallF && !pcsrcE && (state==IDLE || imem_rvalid) && buffer can absorb.
  - "Can absorb" = buffer empty, or the buffer is draining this cycle (stallD=0).
  - imem_addr = {pcF[XLEN-1:2],2'b00}. Address must stay stable while req=1 && ready=0.
- Response tracking: the request's PC is captured as reqpc at handshake.
- PC update, by priority:
  1. pcsrcE: pcF <= pctargetE, forced aligned.
  2. Handshake: pcF <= pcF+4, wrapping modulo 2^XLEN.
  3. Otherwise hold, including whenever stallF=1.
- Redirect while a request is outstanding, or on the same cycle as rvalid:
  - Set kill. The killed response is discarded on arrival, then kill clears.
  - A new request issues no earlier than the cycle after the killed rvalid.
- Buffer: one entry {instr, pc}.
  - Filled when a non-killed rvalid arrives and IF/ID cannot load (stallD=1).
  - Cleared on pcsrcE or flushD.
- IF/ID register next state, by priority:
  1. flushD or pcsrcE: validD=0, instrD=NOP; pcD/pcplus4D don't-care (drive 0).
  2. stallD: hold all.
  3. Buffer valid: load buffer, validD=1.
  4. Non-killed rvalid: load imem_rdata/reqpc, validD=1.
  5. Else: bubble (validD=0, NOP).
- pcplus4D = pcD+4, registered, wraps.
- Latency: with zero wait-state memory (ready=1, rvalid the next cycle), instruction at PC reaches instrD 2 cycles after its request, and throughput is one instruction per cycle.
- No instruction is ever duplicated or lost except those killed by redirect/flush.

Decomposition:
- riscv_pkg: XLEN, NOP_INSTR=32'h0000_0013, RESET_PC default, fetch_state_t enum {IDLE, WAIT}.
- One natural sub-module, fetch_skid_buf: the 1-entry buffer with fill/drain/clear.

Test Plan:
- Reset, then ready=1 with rvalid one cycle after each request, rdata=addr-derived -> instrD sequence for PCs 0,4,8,12 on consecutive cycles, validD=1, pcplus4D=pcD+4.
- Memory with ready=0 for 3 cycles at PC 0x10 -> imem_addr held at 0x10, validD=0 (NOP) bubbles, then the 0x10 instruction appears once.
- stallD=1 for 2 cycles while rvalid returns 0x14's word -> instrD holds the old value, the buffer captures 0x14, and 0x14 appears once after release with no request issued while the buffer is full.
- pcsrcE=1, pctargetE=0x103 while in WAIT -> pending response dropped, next imem_addr=0x100, next valid pcD=0x100, and validD=0 in the cycle after redirect.
- flushD=1 together with stallD=1 -> flush wins, validD=0, instrD=NOP.
- rst asserted mid-WAIT with rvalid arriving the next cycle -> outputs return to reset values, the stale response is ignored (state IDLE), and fetch restarts at RESET_PC.
